// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared RV32I core encodings and the decode control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_RSV  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_LUI  = 4'b1011;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic       Jump;
        logic       Branch;
        logic [3:0] ALUctrl;
        logic       ALUSrcA;
        logic       ALUSrcB;
        logic [2:0] funct3;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Load-use detection plus stall/flush requests for IF and ID.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import core_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ValidE,
    input  logic              RegWriteE,
    input  logic [1:0]        ResultSrcE,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic              PCSrcE,
    output logic              lu,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD
);

    logic w_rd_match;

    // Rs2D is compared even when decode does not use it; worst case a one-cycle spurious stall.
    assign w_rd_match = (RdE == Rs1D) || (RdE == Rs2D);
    assign lu         = ValidE && RegWriteE && (ResultSrcE == RES_MEM) &&
                        (RdE != '0) && w_rd_match;

    // A redirect discards the decode instruction, so holding it would be pointless.
    assign StallF = lu && !PCSrcE;
    assign StallD = lu && !PCSrcE;
    assign FlushD = PCSrcE;

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe_reg
// Description : Decode->Execute pipeline register with load-use and flush bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteD,
    input  logic [1:0]            ResultSrcD,
    input  logic                  MemWriteD,
    input  logic                  JumpD,
    input  logic                  BranchD,
    input  logic [3:0]            ALUctrlD,
    input  logic                  ALUSrcAD,
    input  logic                  ALUSrcBD,
    input  logic [2:0]            funct3D,
    input  logic [DATA_WIDTH-1:0] RD1D,
    input  logic [DATA_WIDTH-1:0] RD2D,
    input  logic [DATA_WIDTH-1:0] PCD,
    input  logic [DATA_WIDTH-1:0] PCPlus4D,
    input  logic [DATA_WIDTH-1:0] ImmExtD,
    input  logic [REG_AW-1:0]     Rs1D,
    input  logic [REG_AW-1:0]     Rs2D,
    input  logic [REG_AW-1:0]     RdD,
    input  logic                  PCSrcE,
    output logic                  RegWriteE,
    output logic [1:0]            ResultSrcE,
    output logic                  MemWriteE,
    output logic                  JumpE,
    output logic                  BranchE,
    output logic [3:0]            ALUctrlE,
    output logic                  ALUSrcAE,
    output logic                  ALUSrcBE,
    output logic [2:0]            funct3E,
    output logic [DATA_WIDTH-1:0] RD1E,
    output logic [DATA_WIDTH-1:0] RD2E,
    output logic [DATA_WIDTH-1:0] PCE,
    output logic [DATA_WIDTH-1:0] PCPlus4E,
    output logic [DATA_WIDTH-1:0] ImmExtE,
    output logic [REG_AW-1:0]     Rs1E,
    output logic [REG_AW-1:0]     Rs2E,
    output logic [REG_AW-1:0]     RdE,
    output logic                  ValidE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD
);

    ctrl_t                 r_ctrl;
    logic [DATA_WIDTH-1:0] r_rd1;
    logic [DATA_WIDTH-1:0] r_rd2;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_pc4;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [REG_AW-1:0]     r_rs1;
    logic [REG_AW-1:0]     r_rs2;
    logic [REG_AW-1:0]     r_rd;
    logic                  r_valid;

    ctrl_t                 w_ctrl_d;
    logic                  w_lu;

    assign w_ctrl_d = '{
        RegWrite:  RegWriteD,
        ResultSrc: ResultSrcD,
        MemWrite:  MemWriteD,
        Jump:      JumpD,
        Branch:    BranchD,
        ALUctrl:   ALUctrlD,
        ALUSrcA:   ALUSrcAD,
        ALUSrcB:   ALUSrcBD,
        funct3:    funct3D
    };

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .ValidE     (r_valid),
        .RegWriteE  (r_ctrl.RegWrite),
        .ResultSrcE (r_ctrl.ResultSrc),
        .RdE        (r_rd),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .PCSrcE     (PCSrcE),
        .lu         (w_lu),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD)
    );

    // A bubble is an all-zero slot: every write, branch and jump enable is inactive.
    always_ff @(posedge clk) begin
        if (rst || PCSrcE || w_lu) begin
            r_ctrl  <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_pc    <= '0;
            r_pc4   <= '0;
            r_imm   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_ctrl  <= w_ctrl_d;
            r_rd1   <= RD1D;
            r_rd2   <= RD2D;
            r_pc    <= PCD;
            r_pc4   <= PCPlus4D;
            r_imm   <= ImmExtD;
            r_rs1   <= Rs1D;
            r_rs2   <= Rs2D;
            r_rd    <= RdD;
            r_valid <= 1'b1;
        end
    end

    assign RegWriteE  = r_ctrl.RegWrite;
    assign ResultSrcE = r_ctrl.ResultSrc;
    assign MemWriteE  = r_ctrl.MemWrite;
    assign JumpE      = r_ctrl.Jump;
    assign BranchE    = r_ctrl.Branch;
    assign ALUctrlE   = r_ctrl.ALUctrl;
    assign ALUSrcAE   = r_ctrl.ALUSrcA;
    assign ALUSrcBE   = r_ctrl.ALUSrcB;
    assign funct3E    = r_ctrl.funct3;
    assign RD1E       = r_rd1;
    assign RD2E       = r_rd2;
    assign PCE        = r_pc;
    assign PCPlus4E   = r_pc4;
    assign ImmExtE    = r_imm;
    assign Rs1E       = r_rs1;
    assign Rs2E       = r_rs2;
    assign RdE        = r_rd;
    assign ValidE     = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_pipe_reg
// Description : Directed vector table plus random instruction stream for id_ex_pipe_reg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic [3:0]  alu_ctrl;
        logic        alu_src_a;
        logic        alu_src_b;
        logic [2:0]  funct3;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } instr_t;

    typedef struct {
        logic rst;
        logic pcsrc;
        int   d_sel;
        logic chk_comb;
        logic exp_stall;
        logic exp_flush;
        int   exp_sel;
    } vec_t;

    localparam int NV = 21;
    localparam int RN = 300;

    logic clk = 1'b0;
    logic rst;
    logic PCSrcE;
    instr_t d_in;
    instr_t e_out;

    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcAE, ALUSrcBE, ValidE;
    logic        StallF, StallD, FlushD;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUctrlE;
    logic [2:0]  funct3E;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0]  Rs1E, Rs2E, RdE;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(
        .DATA_WIDTH (32),
        .REG_AW     (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteD  (d_in.reg_write),
        .ResultSrcD (d_in.result_src),
        .MemWriteD  (d_in.mem_write),
        .JumpD      (d_in.jump),
        .BranchD    (d_in.branch),
        .ALUctrlD   (d_in.alu_ctrl),
        .ALUSrcAD   (d_in.alu_src_a),
        .ALUSrcBD   (d_in.alu_src_b),
        .funct3D    (d_in.funct3),
        .RD1D       (d_in.rd1),
        .RD2D       (d_in.rd2),
        .PCD        (d_in.pc),
        .PCPlus4D   (d_in.pc4),
        .ImmExtD    (d_in.imm),
        .Rs1D       (d_in.rs1),
        .Rs2D       (d_in.rs2),
        .RdD        (d_in.rd),
        .PCSrcE     (PCSrcE),
        .RegWriteE  (RegWriteE),
        .ResultSrcE (ResultSrcE),
        .MemWriteE  (MemWriteE),
        .JumpE      (JumpE),
        .BranchE    (BranchE),
        .ALUctrlE   (ALUctrlE),
        .ALUSrcAE   (ALUSrcAE),
        .ALUSrcBE   (ALUSrcBE),
        .funct3E    (funct3E),
        .RD1E       (RD1E),
        .RD2E       (RD2E),
        .PCE        (PCE),
        .PCPlus4E   (PCPlus4E),
        .ImmExtE    (ImmExtE),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .ValidE     (ValidE),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD)
    );

    assign e_out = '{RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUctrlE, ALUSrcAE,
                     ALUSrcBE, funct3E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE};

    function automatic instr_t mk(input logic rw, input logic [1:0] rs, input logic mw,
                                  input logic j, input logic b, input logic [3:0] alu,
                                  input logic sa, input logic sb, input logic [2:0] f3,
                                  input logic [4:0] s1, input logic [4:0] s2,
                                  input logic [4:0] d, input logic [31:0] pc);
        instr_t t;
        t = '{rw, rs, mw, j, b, alu, sa, sb, f3,
              pc ^ 32'hA5A5_0000, ~pc, pc, pc + 32'd4, {pc[27:0], 4'h0} | {27'd0, d},
              s1, s2, d};
        return t;
    endfunction

    task automatic check_e(input string name, input logic exp_v, input instr_t exp_i);
        n_checks++;
        if (ValidE !== exp_v || e_out !== exp_i) begin
            n_fail++;
            $display("FAIL %s: got ValidE=%0b E=%h, expected ValidE=%0b E=%h",
                     name, ValidE, e_out, exp_v, exp_i);
        end
    endtask

    task automatic check_comb(input string name, input logic exp_s, input logic exp_f);
        n_checks++;
        if ({StallF, StallD, FlushD} !== {exp_s, exp_s, exp_f}) begin
            n_fail++;
            $display("FAIL %s: got StallF=%0b StallD=%0b FlushD=%0b, expected %0b %0b %0b",
                     name, StallF, StallD, FlushD, exp_s, exp_s, exp_f);
        end
    endtask

    instr_t lib [11];
    vec_t   vecs [NV];
    instr_t prog [RN];

    initial begin
        // ALU/ctrl values written numerically: ADD=0 SUB=1 XOR=4, LOAD result=01, PC+4 result=10
        lib[0]  = '1;
        lib[1]  = mk(1, 2'b00, 0, 0, 0, 4'b0000, 0, 0, 3'd0, 5'd1, 5'd2, 5'd3, 32'h100); // ADD x3,x1,x2
        lib[2]  = mk(1, 2'b00, 0, 0, 0, 4'b0100, 0, 0, 3'd4, 5'd3, 5'd1, 5'd4, 32'h104); // XOR x4,x3,x1
        lib[3]  = mk(1, 2'b01, 0, 0, 0, 4'b0000, 0, 1, 3'd2, 5'd1, 5'd0, 5'd5, 32'h108); // LW x5,0(x1)
        lib[4]  = mk(1, 2'b00, 0, 0, 0, 4'b0000, 0, 0, 3'd0, 5'd5, 5'd2, 5'd6, 32'h10C); // ADD x6,x5,x2
        lib[5]  = mk(1, 2'b01, 0, 0, 0, 4'b0000, 0, 1, 3'd2, 5'd1, 5'd0, 5'd0, 32'h110); // LW x0
        lib[6]  = mk(1, 2'b00, 0, 0, 0, 4'b0000, 0, 0, 3'd0, 5'd0, 5'd2, 5'd7, 32'h114); // ADD x7,x0,x2
        lib[7]  = mk(0, 2'b00, 1, 0, 0, 4'b0000, 0, 1, 3'd2, 5'd1, 5'd5, 5'd4, 32'h118); // SW x5,4(x1)
        lib[8]  = mk(0, 2'b00, 0, 0, 1, 4'b0001, 0, 0, 3'd0, 5'd6, 5'd7, 5'd0, 32'h11C); // BEQ x6,x7
        lib[9]  = mk(1, 2'b10, 0, 1, 0, 4'b0000, 1, 1, 3'd0, 5'd0, 5'd0, 5'd1, 32'h120); // JAL x1
        lib[10] = mk(1, 2'b11, 1, 0, 0, 4'b1111, 1, 0, 3'd7, 5'd2, 5'd3, 5'd5, 32'h124); // illegal, rd=5

        //          rst pcs  D   chk stall flush exp(-1=bubble)
        vecs[0]  = '{1, 0,  0,  0, 0, 0, -1};
        vecs[1]  = '{1, 0,  0,  1, 0, 0, -1};
        vecs[2]  = '{0, 0,  1,  1, 0, 0,  1};
        vecs[3]  = '{0, 0,  2,  1, 0, 0,  2};
        vecs[4]  = '{0, 0,  3,  1, 0, 0,  3};
        vecs[5]  = '{0, 0,  4,  1, 1, 0, -1};
        vecs[6]  = '{0, 0,  4,  1, 0, 0,  4};
        vecs[7]  = '{0, 0,  5,  1, 0, 0,  5};
        vecs[8]  = '{0, 0,  6,  1, 0, 0,  6};
        vecs[9]  = '{0, 0,  3,  1, 0, 0,  3};
        vecs[10] = '{0, 0,  7,  1, 1, 0, -1};
        vecs[11] = '{0, 0,  7,  1, 0, 0,  7};
        vecs[12] = '{0, 0,  3,  1, 0, 0,  3};
        vecs[13] = '{0, 1,  4,  1, 0, 1, -1};
        vecs[14] = '{0, 0,  8,  1, 0, 0,  8};
        vecs[15] = '{0, 0,  9,  1, 0, 0,  9};
        vecs[16] = '{0, 0,  3,  1, 0, 0,  3};
        vecs[17] = '{1, 0,  4,  1, 1, 0, -1};
        vecs[18] = '{0, 0,  4,  1, 0, 0,  4};
        vecs[19] = '{0, 0, 10,  1, 0, 0, 10};
        vecs[20] = '{0, 0,  4,  1, 0, 0,  4};

        for (int i = 0; i < NV; i++) begin
            rst    = vecs[i].rst;
            PCSrcE = vecs[i].pcsrc;
            d_in   = lib[vecs[i].d_sel];
            #1;
            if (vecs[i].chk_comb)
                check_comb($sformatf("vec%0d_comb", i), vecs[i].exp_stall, vecs[i].exp_flush);
            @(posedge clk);
            #1;
            if (vecs[i].exp_sel < 0)
                check_e($sformatf("vec%0d_e", i), 1'b0, '0);
            else
                check_e($sformatf("vec%0d_e", i), 1'b1, lib[vecs[i].exp_sel]);
        end

        // Random stream: the model tracks which program index sits in decode and in execute.
        for (int k = 0; k < RN; k++) begin
            logic is_ld;
            is_ld   = ($urandom_range(0, 9) < 4);
            prog[k] = mk(is_ld ? 1'b1 : 1'($urandom_range(0, 1)),
                         is_ld ? 2'b01 : 2'($urandom_range(0, 3) == 1 ? 0 : $urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)),
                         5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 32'(k * 4));
            prog[k].rd1 = $urandom;
            prog[k].imm = $urandom;
        end

        begin
            int  d_idx, e_idx, cyc, n_entered, n_flushed, n_seen;
            logic r, p, hz;
            d_idx = 0; e_idx = -1; cyc = 0; n_entered = 0; n_flushed = 0; n_seen = 0;
            // Leave directed state behind with a clean reset edge.
            rst = 1; PCSrcE = 0; d_in = prog[0];
            @(posedge clk); #1;
            while (d_idx < RN && cyc < 3000) begin
                cyc++;
                r = ($urandom_range(0, 49) == 0);
                p = ($urandom_range(0, 7) == 0);
                rst = r; PCSrcE = p; d_in = prog[d_idx];
                #1;
                hz = (e_idx >= 0) && prog[e_idx].reg_write && prog[e_idx].result_src == 2'b01 &&
                     prog[e_idx].rd != 5'd0 &&
                     (prog[e_idx].rd == prog[d_idx].rs1 || prog[e_idx].rd == prog[d_idx].rs2);
                check_comb("rand_comb", hz && !p, p);
                @(posedge clk); #1;
                if (r) begin
                    e_idx = -1;
                end else if (p) begin
                    e_idx = -1; d_idx++; n_flushed++;
                end else if (hz) begin
                    e_idx = -1;
                end else begin
                    e_idx = d_idx; d_idx++; n_entered++;
                end
                if (e_idx < 0) check_e("rand_e", 1'b0, '0);
                else           check_e("rand_e", 1'b1, prog[e_idx]);
                if (ValidE === 1'b1) n_seen++;
            end
            n_checks++;
            if (d_idx < RN) begin
                n_fail++;
                $display("FAIL rand_budget: consumed %0d of %0d instructions", d_idx, RN);
            end
            n_checks++;
            if (n_seen != RN - n_flushed) begin
                n_fail++;
                $display("FAIL rand_order_count: valid slots %0d, expected issued minus flushed %0d",
                         n_seen, RN - n_flushed);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
